fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised successor fetch stage. Owns the PC and selects next PC from sequential/redirect sources.
//  Reads 32-bit windows from the combinational instruction memory and splits them into 16/32-bit instructions.
//  Buffers fetched instructions in a DEPTH-entry prefetch queue; hands them to decode over a valid/ready handshake.
//  Sits between INST_MEM and the fetch/decode boundary; decode back-pressure replaces the old buffer enable.
// PARAMETERS
//  ADDR_W   32  PC / memory address width (byte address, 16-bit parcel granularity, bit0 always 0)
//  DEPTH    4   prefetch queue entries, power of two, >=2
//  IRQ_W    3   interrupt index width
//  CALL_W   16  call target width, zero-extended to ADDR_W
//  LEN_BIT  15  bit of the first parcel; 1 = 32-bit instruction, 0 = 16-bit
// PORTS
//  clk           in   1        clock; all state updates on rising edge
//  rst           in   1        synchronous, active-high reset
//  reset_vec     in   ADDR_W   PC loaded on reset and on PC_RESET redirect
//  redir_valid   in   1        redirect request this cycle
//  redir_src     in   3        pc_src_e selector (fetch_pkg)
//  fixed_idx     in   2        fixed-vector index; target = fixed_idx*2
//  ivt_base      in   ADDR_W   interrupt vector table base
//  irq_index     in   IRQ_W    interrupt index; target = ivt_base + irq_index
//  ret_addr      in   ADDR_W   return target
//  call_target   in   CALL_W   call target
//  imem_addr     out  ADDR_W   memory read address (= PC), combinational from PC register
//  imem_data     in   32       {parcel@PC in [31:16], parcel@PC+2 in [15:0]}, same-cycle
//  out_valid     out  1        queue head holds an instruction
//  out_ready     in   1        decode accepts head
//  out_instr     out  32       head instruction; 16-bit instrs in [31:16], [15:0]=0
//  out_pc        out  ADDR_W   PC of head instruction
//  out_is32      out  1        head is a 32-bit instruction
// BEHAVIOUR
//  Reset: PC<=reset_vec; queue empty; out_valid=0, out_instr=0, out_pc=0, out_is32=0.
//  Fetch/push each cycle when (count<DEPTH || pop) && !redir_valid && !rst:
//   is32=imem_data[16+LEN_BIT]; push {PC, is32?imem_data:{imem_data[31:16],16'h0}, is32};
//   PC<=PC+(is32?4:2), modulo 2^ADDR_W (wraps silently).
//  Pop when out_valid && out_ready; head advances same edge.
//  Queue full, no pop: PC holds, no push; memory read is ignored.
//  Full + pop same cycle: push and pop both occur; count unchanged.
//  Empty: out_valid=0; a push becomes visible next cycle (fetch-to-out latency 1 cycle).
//  Outputs driven from registered queue head; out_* hold stable while out_valid && !out_ready.
//  Redirect (redir_valid=1): PC<=target, queue flushed (count<=0, pointers reset), no push.
//   A handshake in the redirect cycle is consumed by decode but dropped by the queue (flush wins).
//   Targets: PC_RESET=reset_vec, PC_FIXED={fixed_idx,1'b0}, PC_IVT=ivt_base+irq_index (zero-extended),
//            PC_RET=ret_addr, PC_CALL={0,call_target}; undefined codes behave as PC_RESET.
//   First redirected instruction reaches out_valid 2 cycles after redirect edge.
//  rst overrides redir_valid and all other inputs; reset mid-stream drops all queued entries.
//  Pointers log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] (cycles with queue full, no pop),
//   perf_redir_cnt[31:0] (redirects accepted); both cleared by rst, saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  fetch_pkg: pc_src_e {PC_RESET=0,PC_FIXED=1,PC_IVT=2,PC_RET=3,PC_CALL=4}, PARCEL_W=16, FETCH_W=32.
//  Sub-module fetch_queue: synchronous FIFO with push/pop/flush, width ADDR_W+33, registered head.
//  Top holds PC register, target mux, length decode, perf counters.
// TESTING
//  rst=1 2 cycles, reset_vec=0x100 -> imem_addr=0x100, out_valid=0; cycle after release out_valid=0, next=1, out_pc=0x100.
//  Mixed stream: 16b@0x100, 32b@0x102, 16b@0x106, out_ready=1 -> out_pc 0x100,0x102,0x106; out_is32 0,1,0.
//  out_ready=0, DEPTH=4 -> 4 pushes, then PC holds; out_instr stable; release -> order preserved, no loss.
//  Redirect PC_IVT, ivt_base=0x40, irq_index=5, queue 3 full -> flush, out_valid=0 next cycle, out_pc=0x45... (aligned 0x44 with index 4) 2 cycles later.
//  PC_CALL call_target=0xBEEF, ADDR_W=32 -> out_pc=0x0000BEEF path; PC=0xFFFFFFFE with 32b instr -> wraps to 0x2.
//  rst asserted while redir_valid=1 and queue non-empty -> PC=reset_vec, out_valid=0; with FETCH_PERF_CNT_EN counters=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch/prefetch stage.
package fetch_pkg;

  localparam int unsigned PARCEL_W = 16;
  localparam int unsigned FETCH_W  = 32;

  typedef enum logic [2:0] {
    PC_RESET = 3'd0,
    PC_FIXED = 3'd1,
    PC_IVT   = 3'd2,
    PC_RET   = 3'd3,
    PC_CALL  = 3'd4
  } pc_src_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO with push/pop/flush; head is read from registered storage and
// forced to zero while empty.
module fetch_queue #(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign valid     = (r_count != '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop && valid;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = valid ? r_mem[r_rd_ptr] : '0;

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC register, redirect target mux, 16/32-bit length decode and
// prefetch queue. Optional performance counters under FETCH_PERF_CNT_EN.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IRQ_W   = 3,
  parameter int unsigned CALL_W  = 16,
  parameter int unsigned LEN_BIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  reset_vec,
  input  logic               redir_valid,
  input  logic [2:0]         redir_src,
  input  logic [1:0]         fixed_idx,
  input  logic [ADDR_W-1:0]  ivt_base,
  input  logic [IRQ_W-1:0]   irq_index,
  input  logic [ADDR_W-1:0]  ret_addr,
  input  logic [CALL_W-1:0]  call_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [FETCH_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FETCH_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_is32
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_redir_cnt
`endif
);

  localparam int unsigned Q_W = ADDR_W + FETCH_W + 1;

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [FETCH_W-1:0] w_instr;
  logic [Q_W-1:0]     w_wdata;
  logic [Q_W-1:0]     w_head;
  logic               w_is32;
  logic               w_full;
  logic               w_valid;
  logic               w_pop;
  logic               w_push;

  // Redirect target; unknown selector codes fall back to the reset vector.
  always_comb begin
    w_target = reset_vec;
    case (pc_src_e'(redir_src))
      PC_RESET: w_target = reset_vec;
      PC_FIXED: w_target = ADDR_W'({fixed_idx, 1'b0});
      PC_IVT:   w_target = ivt_base + ADDR_W'(irq_index);
      PC_RET:   w_target = ret_addr;
      PC_CALL:  w_target = ADDR_W'(call_target);
      default:  w_target = reset_vec;
    endcase
  end

  assign w_is32   = imem_data[PARCEL_W + LEN_BIT];
  assign w_instr  = w_is32 ? imem_data : {imem_data[FETCH_W-1:PARCEL_W], PARCEL_W'(0)};
  assign w_pc_inc = w_is32 ? ADDR_W'(4) : ADDR_W'(2);
  assign w_pop    = w_valid && out_ready;
  assign w_push   = (!w_full || w_pop) && !redir_valid;
  assign w_wdata  = {r_pc, w_instr, w_is32};

  always_ff @(posedge clk) begin
    if (rst)              r_pc <= reset_vec;
    else if (redir_valid) r_pc <= w_target;
    else if (w_push)      r_pc <= r_pc + w_pc_inc;
  end

  fetch_queue #(
    .W     (Q_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redir_valid),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .head  (w_head),
    .valid (w_valid),
    .full  (w_full)
  );

  assign imem_addr = r_pc;
  assign out_valid = w_valid;
  assign out_pc    = w_head[Q_W-1 -: ADDR_W];
  assign out_instr = w_head[FETCH_W:1];
  assign out_is32  = w_head[0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_redir_cnt;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_full && !w_pop && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (redir_valid && (r_redir_cnt != '1))      r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_redir_cnt = r_redir_cnt;
`endif

endmodule
